esm_issue_buffer: RTL and testbench

//  Instruction buffer and issue stage that sits at the other end of the ESM IIM

---
 rtl/esm_issue_buffer.sv | 110 +++++++++++
 tb/tb_esm_issue_buffer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/esm_issue_buffer.sv
// ESM issue buffer: holds instructions in slots, publishes the independent map,
// and issues the slot the IIM proposes through a held valid/ready output.
module esm_issue_buffer #(
  parameter  int bs      = 16,
  parameter  int iw      = 32,
  localparam int bs_bits = $clog2(bs)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [iw-1:0]      in_instr,
  output logic               in_ready,
  input  logic [0:bs-1]      ready_mask,
  output logic [0:bs-1]      independent_instr,
  input  logic [bs_bits-1:0] next_buffer_index,
  input  logic               valid_count,
  output logic [bs_bits-1:0] buffer_index,
  output logic               proceed,
  output logic               out_valid,
  output logic [iw-1:0]      out_instr,
  output logic [bs_bits-1:0] out_index,
  input  logic               out_ready,
  output logic [bs_bits:0]   occupancy
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [bs_bits:0] full_cnt = (bs_bits+1)'(bs);
  localparam logic [bs_bits:0] one_cnt  = (bs_bits+1)'(1);

  state_t             state_q, state_d;
  logic [0:bs-1]      entry_valid;
  logic [iw-1:0]      mem [bs];
  logic [bs_bits-1:0] fill_idx;
  logic               fill_en;
  logic               slot_ok;
  logic               can_issue;

  assign in_ready          = occupancy < full_cnt;
  assign independent_instr = entry_valid & ready_mask;
  assign fill_en           = in_valid & in_ready & ~flush;
  assign slot_ok           = entry_valid[next_buffer_index]
                           & ready_mask[next_buffer_index];
  assign can_issue         = valid_count & slot_ok & ~flush
                           & ((state_q == IDLE)
                           | ((state_q == HOLD) & out_ready));
  assign out_valid         = state_q == HOLD;

  // Lowest free slot wins; loop runs high to low so the last hit is lowest.
  always_comb begin
    fill_idx = '0;
    for (int i = bs-1; i >= 0; i--) begin
      if (!entry_valid[i]) fill_idx = bs_bits'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (can_issue) state_d = HOLD;
      HOLD: if (flush | (out_ready & ~can_issue)) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_valid <= '0;
      occupancy   <= '0;
    end else if (flush) begin
      entry_valid <= '0;
      occupancy   <= '0;
    end else begin
      if (fill_en)   entry_valid[fill_idx]          <= 1'b1;
      if (can_issue) entry_valid[next_buffer_index] <= 1'b0;
      unique case ({fill_en, can_issue})
        2'b10:   occupancy <= occupancy + one_cnt;
        2'b01:   occupancy <= occupancy - one_cnt;
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_instr    <= '0;
      out_index    <= '0;
      buffer_index <= '0;
      proceed      <= 1'b0;
    end else begin
      proceed <= can_issue;
      if (can_issue) begin
        out_instr    <= mem[next_buffer_index];
        out_index    <= next_buffer_index;
        buffer_index <= next_buffer_index;
      end
    end
  end

  // Slot storage needs no reset; entry_valid qualifies every read.
  always_ff @(posedge clk) begin
    if (fill_en) mem[fill_idx] <= in_instr;
  end

endmodule

// File: tb/tb_esm_issue_buffer.sv
// Bench for esm_issue_buffer: slot-array reference model, issue scoreboard
// popped by a monitor on each proceed pulse, directed then random stimulus.
module tb_esm_issue_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic        in_ready;
  logic [0:15] ready_mask = '1;
  logic [0:15] independent_instr;
  logic [3:0]  next_buffer_index = '0;
  logic        valid_count = 1'b0;
  logic [3:0]  buffer_index;
  logic        proceed;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [3:0]  out_index;
  logic        out_ready = 1'b0;
  logic [4:0]  occupancy;

  esm_issue_buffer #(.bs(16), .iw(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .ready_mask(ready_mask), .independent_instr(independent_instr),
    .next_buffer_index(next_buffer_index), .valid_count(valid_count),
    .buffer_index(buffer_index), .proceed(proceed),
    .out_valid(out_valid), .out_instr(out_instr), .out_index(out_index),
    .out_ready(out_ready), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    int          idx;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;

  bit          mv[16];
  logic [31:0] mm[16];
  int          mocc;
  bit          mhold;
  bit          mproc;
  logic [31:0] mout;
  int          moidx;
  int          mbidx;

  localparam logic [31:0] A = 32'hAAAA_0001;
  localparam logic [31:0] B = 32'hBBBB_0002;
  localparam logic [31:0] C = 32'hCCCC_0003;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic void mreset();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    mocc = 0; mhold = 0; mproc = 0;
    mout = '0; moidx = 0; mbidx = 0;
  endfunction

  task automatic check_outputs();
    logic [0:15] ind;
    for (int i = 0; i < 16; i++) ind[i] = mv[i] & ready_mask[i];
    chk("independent_instr", independent_instr, ind);
    chk("occupancy", occupancy, mocc);
    chk("in_ready", in_ready, mocc < 16);
    chk("out_valid", out_valid, mhold);
    chk("proceed", proceed, mproc);
    chk("buffer_index", buffer_index, mbidx);
    if (mhold) begin
      chk("out_instr", out_instr, mout);
      chk("out_index", out_index, moidx);
    end
  endtask

  // Apply this cycle's inputs to the slot model, as of the coming edge.
  task automatic mstep();
    int fs;
    int k;
    bit fill;
    bit can;
    if (flush) begin
      for (int i = 0; i < 16; i++) mv[i] = 1'b0;
      mocc = 0; mhold = 0; mproc = 0;
    end else begin
      fs = -1;
      for (int i = 15; i >= 0; i--) if (!mv[i]) fs = i;
      k = int'(next_buffer_index);
      fill = in_valid && (mocc < 16);
      can = valid_count && mv[k] && ready_mask[k] && (!mhold || out_ready);
      mproc = can;
      if (can) begin
        q.push_back('{mm[k], k});
        mout = mm[k]; moidx = k; mbidx = k;
        mv[k] = 1'b0; mhold = 1;
      end else if (mhold && out_ready) begin
        mhold = 0;
      end
      if (fill) begin
        mm[fs] = in_instr; mv[fs] = 1'b1;
      end
      mocc += int'(fill) - int'(can);
    end
  endtask

  task automatic cyc(bit iv, logic [31:0] ins, logic [0:15] msk,
                     int nbi, bit vc, bit ordy, bit fl);
    @(negedge clk);
    in_valid = iv; in_instr = ins; ready_mask = msk;
    next_buffer_index = 4'(nbi); valid_count = vc;
    out_ready = ordy; flush = fl;
    #1;
    check_outputs();
    mstep();
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst && proceed) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL issue_unexpected: got idx %0d expected none", out_index);
        end else begin
          e = q.pop_front();
          chk("issue_instr", out_instr, e.instr);
          chk("issue_index", out_index, e.idx);
        end
      end
    end
  end

  initial begin
    int cand[$];
    int nbi;
    mreset();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_buffer_index", buffer_index, 0);
    chk("rst_proceed", proceed, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_independent", independent_instr, 16'h0000);
    rst = 1'b1;

    cyc(0, '0, '1, 0, 0, 0, 0);
    cyc(1, A, '1, 0, 0, 0, 0);
    cyc(1, B, '1, 0, 0, 0, 0);
    cyc(1, C, '1, 0, 0, 0, 0);
    cyc(0, '0, '1, 1, 1, 1, 0);
    chk("t2_independent", independent_instr, 16'hE000);
    chk("t2_occupancy", occupancy, 3);

    cyc(0, '0, '1, 1, 1, 0, 0);
    chk("t3_proceed", proceed, 1);
    chk("t3_out_instr", out_instr, B);
    chk("t3_independent", independent_instr, 16'hA000);
    cyc(0, '0, '1, 1, 1, 0, 0);
    chk("t4_stale_proceed", proceed, 0);

    repeat (4) cyc(0, '0, '1, 0, 1, 0, 0);
    chk("t5_held_instr", out_instr, B);
    cyc(0, '0, '1, 0, 1, 1, 0);
    cyc(0, '0, '1, 0, 0, 1, 0);
    chk("t5_b2b_valid", out_valid, 1);
    chk("t5_b2b_instr", out_instr, A);

    for (int i = 0; i < 15; i++) cyc(1, $urandom, '1, 0, 0, 1, 0);
    cyc(1, 32'h5151_0000, '1, 2, 1, 1, 0);
    chk("t6_full_in_ready", in_ready, 0);
    chk("t6_full_occupancy", occupancy, 16);
    cyc(1, 32'h7777_0002, '1, 0, 0, 1, 0);
    cyc(1, 32'h5252_0000, '1, 5, 1, 1, 0);
    cyc(1, 32'h7777_0005, '1, 6, 1, 1, 0);
    cyc(0, '0, '1, 2, 1, 1, 0);
    cyc(1, $urandom, '1, 3, 1, 1, 1);
    cyc(0, '0, '1, 0, 0, 1, 0);
    chk("t6_flush_occupancy", occupancy, 0);
    chk("t6_flush_out_valid", out_valid, 0);

    for (int n = 0; n < 400; n++) begin
      cand.delete();
      for (int i = 0; i < 16; i++) if (mv[i]) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(0, 9) < 6)
        nbi = cand[$urandom_range(0, cand.size() - 1)];
      else
        nbi = $urandom_range(0, 15);
      cyc(bit'($urandom_range(0, 1)), $urandom, 16'($urandom | $urandom),
          nbi, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
          $urandom_range(0, 49) == 0);
    end

    cyc(0, '0, '1, 0, 0, 1, 1);
    cyc(1, 32'hD00D_0000, '1, 0, 0, 1, 0);
    cyc(0, '0, '1, 0, 1, 0, 0);
    cyc(0, '0, '1, 0, 0, 0, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_occupancy", occupancy, 0);
    chk("arst_independent", independent_instr, 16'h0000);
    mreset();
    @(negedge clk);
    rst = 1'b1;
    cyc(0, '0, '1, 0, 1, 1, 0);
    cyc(0, '0, '1, 0, 0, 1, 0);
    chk("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
